// File: rtl/regfile_pkg.sv
// Shared widths, enable levels and sweep FSM encodings for the 32 x 32 register file.
package regfile_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM      = 32;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic RST_ENABLE   = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entry 0 is hardwired, so the clear sweep covers 1..REG_NUM-1 only.
  localparam logic [REG_ADDR_BUS-1:0] SWEEP_FIRST = REG_ADDR_BUS'(1);
  localparam logic [REG_ADDR_BUS-1:0] SWEEP_LAST  = REG_ADDR_BUS'(REG_NUM - 1);

endpackage

// File: rtl/regfile.sv
// Two-read / one-write register file with a 31-cycle clear sweep after reset; reads are combinational.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_ADDR_BUS-1:0] waddr,
  input  logic [REG_BUS-1:0]      wdata,
  input  logic                    re1,
  input  logic [REG_ADDR_BUS-1:0] raddr1,
  input  logic                    re2,
  input  logic [REG_ADDR_BUS-1:0] raddr2,
  output logic [REG_BUS-1:0]      rdata1,
  output logic [REG_BUS-1:0]      rdata2,
  output logic                    ready
);

  state_t                  state;
  logic [REG_ADDR_BUS-1:0] sweep_cnt;
  logic                    run;

  logic [REG_BUS-1:0]      mem [REG_NUM];
  logic                    mem_we;
  logic [REG_ADDR_BUS-1:0] mem_addr;
  logic [REG_BUS-1:0]      mem_dat;

  logic                    in_rst;
  logic                    byp1;
  logic                    byp2;

  assign in_rst = (rst == RST_ENABLE);

  // The counter parks on the last entry rather than wrapping back to the hardwired zero.
  always_ff @(posedge clk) begin
    if (in_rst) begin
      state     <= ST_INIT;
      sweep_cnt <= SWEEP_FIRST;
      run       <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_cnt == SWEEP_LAST) begin
            state <= ST_RUN;
            run   <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        ST_RUN: run <= 1'b1;
      endcase
    end
  end

  assign ready = run & ~in_rst;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = sweep_cnt;
    mem_dat  = ZERO_WORD;
    if (!in_rst) begin
      if (state == ST_INIT) begin
        mem_we = 1'b1;
      end else if (we == WRITE_ENABLE && waddr != '0) begin
        mem_we   = 1'b1;
        mem_addr = waddr;
        mem_dat  = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_dat;
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = (we == WRITE_ENABLE) && (waddr == raddr1);
  assign byp2 = (we == WRITE_ENABLE) && (waddr == raddr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  function automatic logic [REG_BUS-1:0] read_port(
    input logic                    rdy,
    input logic                    en,
    input logic [REG_ADDR_BUS-1:0] ra,
    input logic                    byp,
    input logic [REG_BUS-1:0]      fwd,
    input logic [REG_BUS-1:0]      arr
  );
    if (!rdy || en != READ_ENABLE || ra == '0) return ZERO_WORD;
    if (byp) return fwd;
    return arr;
  endfunction

  assign rdata1 = read_port(ready, re1, raddr1, byp1, wdata, mem[raddr1]);
  assign rdata2 = read_port(ready, re2, raddr2, byp2, wdata, mem[raddr2]);

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed sweep/write/r0/bypass/read-enable/reset cases plus random traffic vs. an array model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        ready;

  int          checks = 0;
  int          errors = 0;
  string       phase = "reset";

  // Model: register contents plus the number of rst-low edges since the last reset.
  logic [31:0] model [32];
  int          swept = 0;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    return !rst && swept >= 31;
  endfunction

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] ra);
    if (!exp_ready() || !en || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == ra) return wdata;
`endif
    return model[ra];
  endfunction

  // One clock: drive at the falling edge, check combinational outputs, then apply the model at the rising edge.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
    chk({phase, "/ready"}, {31'b0, ready}, {31'b0, exp_ready()});
    chk({phase, "/rdata1"}, rdata1, exp_rd(re1, raddr1));
    chk({phase, "/rdata2"}, rdata2, exp_rd(re2, raddr2));
    @(posedge clk);
    if (rst) begin
      swept = 0;
    end else if (swept < 31) begin
      swept++;
      model[swept] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  // Read-only probe against constants fixed by the directed cases; does not advance the clock.
  task automatic peek(input string tag, input logic e1, input logic [4:0] a1, input logic e2,
                      input logic [4:0] a2, input logic [31:0] x1, input logic [31:0] x2);
    we = 1'b0; re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
    chk({tag, "/rdata1"}, rdata1, x1);
    chk({tag, "/rdata2"}, rdata2, x2);
  endtask

  initial begin
    logic [4:0]  wa;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] bypass_exp;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);

    phase = "reset";
    repeat (3) cyc(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 5'd3);

    phase = "sweep";
    for (int i = 0; i < 31; i++)
      cyc(1'b0, 1'b1, 5'($urandom), 32'hFFFF_FFFF, 1'b1, 5'(i), 1'b1, 5'(31 - i));

    phase = "zero";
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i));
    end
    chk("zero/ready_const", {31'b0, ready}, 32'd1);

    phase = "wr_rd";
    cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    peek("wr_rd_const", 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    phase = "r0";
    cyc(1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
    peek("r0_const", 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0);

    phase = "bypass";
    cyc(1'b0, 1'b1, 5'd7, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'hA5A5_A5A5;
`else
    bypass_exp = 32'h0000_0001;
`endif
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; re1 = 1'b1; raddr1 = 5'd7;
    #1;
    chk("bypass_const/rdata1", rdata1, bypass_exp);
    cyc(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
    peek("bypass_next", 1'b1, 5'd7, 1'b0, 5'd7, 32'hA5A5_A5A5, 32'h0);

    peek("re_off", 1'b0, 5'd5, 1'b1, 5'd5, 32'h0, 32'hDEAD_BEEF);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
      cyc(1'b0, 1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0), a1,
          1'($urandom_range(0, 3) != 0), a2);
    end

    phase = "midsweep";
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'($urandom));
    cyc(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd3);
    for (int i = 0; i < 31; i++)
      cyc(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'(i + 1));
    chk("midsweep/ready_const", {31'b0, ready}, 32'd1);
    peek("midsweep_r3", 1'b1, 5'd3, 1'b1, 5'd31, 32'h0, 32'h0);

    phase = "post";
    cyc(1'b0, 1'b1, 5'd31, 32'h0BAD_F00D, 1'b0, 5'd0, 1'b0, 5'd0);
    peek("post_r31", 1'b1, 5'd31, 1'b1, 5'd3, 32'h0BAD_F00D, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
